coord_scan_gen: RTL

//  Sequential raster-window coordinate generator; successor to the combinational index->X/Y splitter.
//  On a start command it walks a rectangular window of a frame whose width is 2^cfg_log2w.

---
 rtl/coord_pkg.sv | 19 +
 rtl/coord_index_calc.sv | 26 ++
 rtl/coord_scan_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/coord_pkg.sv
// coord_pkg: shared types and helpers for the coordinate scan datapath.
//   state_e        scan FSM states (S_IDLE, S_RUN, S_DONE)
//   *_DFLT         default widths for index / coordinate / log2-width fields
//   compose_index  (y << log2w) | x, evaluated at 64 bits; callers truncate
package coord_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int unsigned IDX_W_DFLT   = 16;
  localparam int unsigned COORD_W_DFLT = 16;
  localparam int unsigned LOG2W_W_DFLT = 4;

  function automatic logic [63:0] compose_index(input logic [63:0] x,
                                                input logic [63:0] y,
                                                input logic [5:0]  log2w);
    return (y << log2w) | x;
  endfunction

endpackage

// File: rtl/coord_index_calc.sv
// coord_index_calc: combinational (X, Y, log2w) -> linear frame index.
//   x      in   COORD_W  column
//   y      in   COORD_W  row
//   log2w  in   LOG2W_W  log2 of frame width
//   index  out  IDX_W    (y << log2w) | x, upper bits discarded
module coord_index_calc
  import coord_pkg::*;
#(
  parameter int unsigned IDX_W   = IDX_W_DFLT,
  parameter int unsigned COORD_W = COORD_W_DFLT,
  parameter int unsigned LOG2W_W = LOG2W_W_DFLT
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [LOG2W_W-1:0] log2w,
  output logic [IDX_W-1:0]   index
);

  logic [63:0] full_index;

  always_comb begin
    full_index = compose_index(64'(x), 64'(y), 6'(log2w));
    index      = full_index[IDX_W-1:0];
  end

endmodule

// File: rtl/coord_scan_gen.sv
// coord_scan_gen: sequential raster-window coordinate generator.
// On start it walks a w x h window at (x0, y0) of a frame 2^log2w pixels wide and emits one
// (X, Y, index) beat per out_valid/out_ready handshake.
//   Clk, Reset          clock, synchronous active-high reset
//   start, abort        scan control (abort wins over start)
//   cfg_*               window / frame config, captured when start is taken in S_IDLE
//   out_valid/out_ready beat handshake; X, Y, index, last describe the presented beat
//   RegWrite            out_valid & out_ready write strobe
//   busy, done, cfg_err status; done pulses one cycle, cfg_err held until next start
// Optional macro COORD_SERPENTINE_EN: odd relative rows scan right-to-left.
module coord_scan_gen
  import coord_pkg::*;
#(
  parameter int unsigned IDX_W   = IDX_W_DFLT,
  parameter int unsigned COORD_W = COORD_W_DFLT,
  parameter int unsigned LOG2W_W = LOG2W_W_DFLT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LOG2W_W-1:0] cfg_log2w,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_y0,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [IDX_W-1:0]   index,
  output logic               last,
  output logic               RegWrite,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int unsigned XW    = COORD_W + 1;
  // Wide enough for both x0 + w and 2^log2w without overflow.
  localparam int unsigned FRM_W = (1 << LOG2W_W) + 1;
  localparam int unsigned FW    = (XW > FRM_W) ? XW : FRM_W;

  state_e state_q, state_d;

  logic [XW-1:0]      x_q, x_d, y_q, y_d;
  logic [XW-1:0]      x0_q, x0_d, xend_q, xend_d, yend_q, yend_d;
  logic [LOG2W_W-1:0] log2w_q, log2w_d;
  logic               err_q, err_d;
`ifdef COORD_SERPENTINE_EN
  logic               odd_q, odd_d;
`endif

  logic [FW-1:0] span, frame;
  logic          oversize, empty, row_end, last_int;

  always_comb begin
    span     = FW'(cfg_x0) + FW'(cfg_w);
    frame    = FW'(1) << cfg_log2w;
    oversize = span > frame;
    empty    = (cfg_w == '0) || (cfg_h == '0);
`ifdef COORD_SERPENTINE_EN
    row_end  = odd_q ? (x_q == x0_q) : (x_q == xend_q);
`else
    row_end  = (x_q == xend_q);
`endif
    last_int = (state_q == S_RUN) && row_end && (y_q == yend_q);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (empty || oversize) ? S_DONE : S_RUN;
      S_RUN:   if (out_ready && last_int) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output logic: everything derives from registers except the write strobe.
  always_comb begin
    out_valid = (state_q == S_RUN);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    cfg_err   = err_q;
    X         = x_q[COORD_W-1:0];
    Y         = y_q[COORD_W-1:0];
    last      = last_int;
    RegWrite  = out_valid & out_ready;
  end

  // Datapath next-state
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    xend_d  = xend_q;
    yend_d  = yend_q;
    log2w_d = log2w_q;
    err_d   = err_q;
`ifdef COORD_SERPENTINE_EN
    odd_d   = odd_q;
`endif
    if (!abort) begin
      if (state_q == S_IDLE && start) begin
        x_d     = XW'(cfg_x0);
        y_d     = XW'(cfg_y0);
        x0_d    = XW'(cfg_x0);
        // End bounds wrap when w/h is zero, but that case never enters S_RUN.
        xend_d  = XW'(cfg_x0) + XW'(cfg_w) - XW'(1);
        yend_d  = XW'(cfg_y0) + XW'(cfg_h) - XW'(1);
        log2w_d = cfg_log2w;
        err_d   = oversize;
`ifdef COORD_SERPENTINE_EN
        odd_d   = 1'b0;
`endif
      end else if (state_q == S_RUN && out_ready && !last_int) begin
`ifdef COORD_SERPENTINE_EN
        // Row turn keeps X at the edge; the new row starts where the old one ended.
        if (row_end) begin
          y_d   = y_q + XW'(1);
          odd_d = ~odd_q;
        end else if (odd_q) begin
          x_d = x_q - XW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
`else
        if (row_end) begin
          x_d = x0_q;
          y_d = y_q + XW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      xend_q  <= '0;
      yend_q  <= '0;
      log2w_q <= '0;
      err_q   <= 1'b0;
`ifdef COORD_SERPENTINE_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      xend_q  <= xend_d;
      yend_q  <= yend_d;
      log2w_q <= log2w_d;
      err_q   <= err_d;
`ifdef COORD_SERPENTINE_EN
      odd_q   <= odd_d;
`endif
    end
  end

  coord_index_calc #(
    .IDX_W  (IDX_W),
    .COORD_W(COORD_W),
    .LOG2W_W(LOG2W_W)
  ) u_index_calc (
    .x    (x_q[COORD_W-1:0]),
    .y    (y_q[COORD_W-1:0]),
    .log2w(log2w_q),
    .index(index)
  );

endmodule
